// File: rtl/rr_merge_sched_if.sv
// Link between upstream streams, the round-robin merge scheduler and the downstream stage.
// The master view belongs to the scheduler; the slave view belongs to the surrounding logic.
interface rr_merge_sched_if #(
    parameter int word_width = 16,
    parameter int num_in     = 4,
    parameter int log_num_in = 2
);
    logic                         busy;
    logic [num_in*word_width-1:0] in_data;
    logic [num_in-1:0]            stall;
    logic [word_width-1:0]        out;
    logic [log_num_in-1:0]        grant_id;

    modport master (
        input  busy,
        input  in_data,
        output stall,
        output out,
        output grant_id
    );

    modport slave (
        output busy,
        output in_data,
        input  stall,
        input  out,
        input  grant_id
    );
endinterface

// File: rtl/rr_merge_sched.sv
// Round-robin scheduler sharing one merge-tree output link among num_in streams,
// with downstream backpressure and a burst limit on how long one input may hold the link.
module rr_merge_sched #(
    parameter int word_width = 16,
    parameter int val_bit    = 1,
    parameter int num_in     = 4,
    parameter int log_num_in = 2,
    parameter int max_burst  = 4,
    parameter int log_burst  = 3
) (
    input  logic               clk,
    input  logic               rst,
    rr_merge_sched_if.master   bus
);

    localparam int                   VALID_MSB = word_width - val_bit;
    localparam logic [log_burst-1:0] MAX_CNT   = log_burst'(max_burst);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [log_num_in-1:0]   owner_r;
    logic [log_burst-1:0]    burst_cnt_r;
    logic [word_width-1:0]   out_r;
    logic [log_num_in-1:0]   grant_id_r;

    logic [num_in-1:0]       req_s;
    logic [num_in-1:0]       gnt_s;
    logic [num_in-1:0]       stall_s;
    logic [log_num_in-1:0]   gnt_idx_s;
    logic                    gnt_vld_s;
    logic                    others_s;
    logic                    owner_keep_s;

    // Extract the per-input request (valid) bits from the packed input bus
    always_comb begin
        req_s = '0;
        for (int i = 0; i < num_in; i++) begin
            req_s[i] = bus.in_data[i*word_width + VALID_MSB];
        end
    end

    // Grant selection: keep the owner while its burst allows, else rotate from owner+1
    always_comb begin
        int   idx_v;
        logic found_v;
        idx_v     = 0;
        found_v   = 1'b0;
        others_s  = 1'b0;
        gnt_idx_s = owner_r;
        for (int i = 0; i < num_in; i++) begin
            if ((i != int'(owner_r)) && req_s[i]) begin
                others_s = 1'b1;
            end else begin
                others_s = others_s;
            end
        end
        // A zero count means no burst is active, so the owner gets no preference
        owner_keep_s = req_s[owner_r] && (burst_cnt_r != {log_burst{1'b0}})
                       && ((burst_cnt_r < MAX_CNT) || !others_s);
        if (owner_keep_s) begin
            gnt_idx_s = owner_r;
        end else begin
            for (int k = 1; k <= num_in; k++) begin
                idx_v = (int'(owner_r) + k) % num_in;
                if (!found_v && req_s[idx_v]) begin
                    found_v   = 1'b1;
                    gnt_idx_s = log_num_in'(idx_v);
                end else begin
                    found_v = found_v;
                end
            end
        end
        gnt_vld_s = !bus.busy && (|req_s);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.busy)       state_nxt_s = BLOCKED;
                else if (|req_s)    state_nxt_s = BURST;
                else                state_nxt_s = IDLE;
            end
            BURST: begin
                if (bus.busy)       state_nxt_s = BLOCKED;
                else if (!(|req_s)) state_nxt_s = IDLE;
                else                state_nxt_s = BURST;
            end
            BLOCKED: begin
                if (bus.busy)       state_nxt_s = BLOCKED;
                else if (|req_s)    state_nxt_s = BURST;
                else                state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: one-hot grant and per-input stall
    always_comb begin
        gnt_s = '0;
        if (gnt_vld_s) begin
            gnt_s[gnt_idx_s] = 1'b1;
        end else begin
            gnt_s = '0;
        end
        stall_s = {num_in{bus.busy}} | (req_s & ~gnt_s);
    end

    // Owner, burst counter and registered output word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_r     <= log_num_in'(num_in - 1);
            burst_cnt_r <= '0;
            out_r       <= '0;
            grant_id_r  <= '0;
        end else if (gnt_vld_s) begin
            out_r      <= bus.in_data[int'(gnt_idx_s)*word_width +: word_width];
            grant_id_r <= gnt_idx_s;
            owner_r    <= gnt_idx_s;
            if (gnt_idx_s != owner_r) begin
                burst_cnt_r <= {{(log_burst-1){1'b0}}, 1'b1};
            end else if (burst_cnt_r >= MAX_CNT) begin
                burst_cnt_r <= MAX_CNT;
            end else begin
                burst_cnt_r <= burst_cnt_r + 1'b1;
            end
        end else if (!bus.busy) begin
            out_r[VALID_MSB] <= 1'b0;
            burst_cnt_r      <= '0;
        end else begin
            out_r <= out_r;
        end
    end

    assign bus.stall    = stall_s;
    assign bus.out      = out_r;
    assign bus.grant_id = grant_id_r;

endmodule

// File: tb/tb_rr_merge_sched.sv
// Directed bench for rr_merge_sched: hand-computed grant order, stall masks and output words.
module tb_rr_merge_sched;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [14:0] pay [4];
    logic [15:0] exp_out;

    rr_merge_sched_if #(.word_width(16), .num_in(4), .log_num_in(2)) bus ();

    rr_merge_sched #(
        .word_width(16), .val_bit(1), .num_in(4), .log_num_in(2),
        .max_burst(4), .log_burst(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // One scheduler cycle: drive requests, check stall, clock, check out and grant_id
    task automatic cyc(input logic [3:0] req, input logic b, input logic [3:0] exp_stall,
                       input logic exp_v, input logic [1:0] exp_gid, input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.in_data[i*16 +: 16] = {req[i], pay[i]};
        end
        bus.busy = b;
        #1;
        vectors++;
        assert (bus.stall === exp_stall) else begin
            miscompares++;
            $error("FAIL %s stall got %b want %b", tag, bus.stall, exp_stall);
        end
        @(posedge clk);
        #1;
        if (!b) begin
            exp_out = exp_v ? {1'b1, pay[exp_gid]} : {1'b0, exp_out[14:0]};
        end
        vectors++;
        assert (bus.out === exp_out) else begin
            miscompares++;
            $error("FAIL %s out got %h want %h", tag, bus.out, exp_out);
        end
        vectors++;
        assert (bus.grant_id === exp_gid) else begin
            miscompares++;
            $error("FAIL %s grant_id got %0d want %0d", tag, bus.grant_id, exp_gid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pay[0] = 15'h0123;
        pay[1] = 15'h1111;
        pay[2] = 15'h2222;
        pay[3] = 15'h3333;
        exp_out     = 16'h0000;
        clk         = 1'b0;
        rst         = 1'b0;
        bus.busy    = 1'b0;
        bus.in_data = 64'h0;
        #2;
        vectors++;
        assert (bus.out === 16'h0000) else begin
            miscompares++;
            $error("FAIL reset_out got %h want %h", bus.out, 16'h0000);
        end
        vectors++;
        assert (bus.grant_id === 2'd0) else begin
            miscompares++;
            $error("FAIL reset_gid got %0d want %0d", bus.grant_id, 2'd0);
        end
        @(negedge clk);
        rst = 1'b1;

        // single request on in0, then drop to idle
        cyc(4'b0001, 1'b0, 4'b0000, 1'b1, 2'd0, "t1_grant0");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "t1_idle");

        // all request: idle scan starts after owner 0, bursts of four
        for (int n = 0; n < 4; n++) cyc(4'b1111, 1'b0, 4'b1101, 1'b1, 2'd1, "t2_burst1");
        for (int n = 0; n < 4; n++) cyc(4'b1111, 1'b0, 4'b1011, 1'b1, 2'd2, "t2_burst2");

        // busy freezes the link, release rotates to the next index
        for (int n = 0; n < 3; n++) cyc(4'b1111, 1'b1, 4'b1111, 1'b1, 2'd2, "t4_busy");
        cyc(4'b1111, 1'b0, 4'b0111, 1'b1, 2'd3, "t4_release");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, "t4_idle");

        // lone in2 saturates its burst, in0 then takes one grant
        for (int n = 0; n < 5; n++) cyc(4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, "t3_solo2");
        cyc(4'b0101, 1'b0, 4'b0100, 1'b1, 2'd0, "t3_preempt0");
        cyc(4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2, "t3_back2");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, "t3_idle");

        // owner 1 at burst limit loses to in3; below the limit it keeps the link
        for (int n = 0; n < 4; n++) cyc(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, "t6_fill1");
        cyc(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd3, "t6_limit");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, "t6_idle");
        for (int n = 0; n < 2; n++) cyc(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd1, "t6_part1");
        cyc(4'b1010, 1'b0, 4'b1000, 1'b1, 2'd1, "t6_keep1");

        // asynchronous reset mid-burst of owner 3
        for (int n = 0; n < 2; n++) cyc(4'b1000, 1'b0, 4'b0000, 1'b1, 2'd3, "t5_own3");
        #2;
        rst = 1'b0;
        #1;
        exp_out = 16'h0000;
        vectors++;
        assert (bus.out === 16'h0000) else begin
            miscompares++;
            $error("FAIL t5_async_out got %h want %h", bus.out, 16'h0000);
        end
        vectors++;
        assert (bus.grant_id === 2'd0) else begin
            miscompares++;
            $error("FAIL t5_async_gid got %0d want %0d", bus.grant_id, 2'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(4'b1001, 1'b0, 4'b1000, 1'b1, 2'd0, "t5_first0");

        // busy with no requests stalls everyone and holds the valid word
        cyc(4'b0000, 1'b1, 4'b1111, 1'b1, 2'd0, "busy_noreq");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
